// File: rtl/sbox_pkg.sv
// Shared types, basis-change matrices and GF(2^8) helpers for the byte-serial SubBytes engine.
package sbox_pkg;

  localparam int unsigned NBYTES = 16;
  localparam int unsigned BLK_W  = 8 * NBYTES;
  localparam int unsigned IDX_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Row i of a matrix is the mask of input bits XORed into output bit i.
  typedef logic [7:0][7:0] mat8_t;

  localparam logic [7:0] AFF_C = 8'h63;

  localparam mat8_t FWD_IN  = {8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
  localparam mat8_t INV_IN  = {8'h52, 8'h29, 8'h94, 8'h4A, 8'h25, 8'h92, 8'h49, 8'hA4};
  localparam mat8_t FWD_OUT = {8'hF8, 8'h7C, 8'h3E, 8'h1F, 8'h8F, 8'hC7, 8'hE3, 8'hF1};
  localparam mat8_t INV_OUT = {8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  function automatic logic [7:0] mat_mul(input mat8_t m, input logic [7:0] x);
    logic [7:0] y;
    for (int i = 0; i < 8; i++) begin
      y[i] = ^(m[i] & x);
    end
    return y;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // x^254 = x^-1 for x != 0, and maps 0 to 0 as SubBytes requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

endpackage

// File: rtl/subbytes_serial_sbox_pipe2.sv
// Two-stage S-box byte datapath: stage A registers the input map, stage B inverts and maps out.
// Stage B's register is the caller's result buffer, so the stage B outputs here are its D side.
module sbox_pipe2
  import sbox_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_byte,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_vld,
  input  logic             mode,
  output logic [7:0]       out_byte,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_vld
);

  logic [7:0]       a_byte_q, a_byte_d;
  logic [IDX_W-1:0] a_idx_q, a_idx_d;
  logic             a_vld_q, a_vld_d;
  logic             a_mode_q, a_mode_d;
  logic [7:0]       b_inv;

  // Stage A: inverse mode strips the affine step before the shared inversion.
  always_comb begin
    a_vld_d  = in_vld;
    a_idx_d  = in_idx;
    a_mode_d = mode;
    a_byte_d = mode ? mat_mul(INV_IN, in_byte ^ AFF_C) : mat_mul(FWD_IN, in_byte);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_byte_q <= 8'h00;
      a_idx_q  <= '0;
      a_vld_q  <= 1'b0;
      a_mode_q <= 1'b0;
    end else begin
      a_byte_q <= a_byte_d;
      a_idx_q  <= a_idx_d;
      a_vld_q  <= a_vld_d;
      a_mode_q <= a_mode_d;
    end
  end

  // Stage B: forward mode applies the affine step after inversion.
  always_comb begin
    b_inv    = gf_inv(a_byte_q);
    out_byte = a_mode_q ? mat_mul(INV_OUT, b_inv) : (mat_mul(FWD_OUT, b_inv) ^ AFF_C);
    out_idx  = a_idx_q;
    out_vld  = a_vld_q;
  end

endmodule

// File: rtl/subbytes_serial.sv
// Byte-serial SubBytes engine: accepts a 128-bit state, substitutes one byte per cycle,
// and presents the reassembled block over a valid/ready handshake.
module subbytes_serial
  import sbox_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  input  logic             in_dec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data
);

  state_t             state_q, state_d;
  logic [IDX_W:0]     issue_cnt_q, issue_cnt_d;
  logic [BLK_W-1:0]   src_q, src_d;
  logic [BLK_W-1:0]   result_q, result_d;
  logic               mode_q, mode_d;

  logic               issue_vld;
  logic [IDX_W-1:0]   issue_idx;
  logic [7:0]         issue_byte;
  logic [7:0]         wb_byte;
  logic [IDX_W-1:0]   wb_idx;
  logic               wb_vld;

  sbox_pipe2 u_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_byte  (issue_byte),
    .in_idx   (issue_idx),
    .in_vld   (issue_vld),
    .mode     (mode_q),
    .out_byte (wb_byte),
    .out_idx  (wb_idx),
    .out_vld  (wb_vld)
  );

  // Issue, writeback and handshake control.
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    src_d       = src_q;
    mode_d      = mode_q;
    result_d    = result_q;
    issue_idx   = issue_cnt_q[IDX_W-1:0];
    issue_vld   = (state_q == RUN) && !issue_cnt_q[IDX_W];
    issue_byte  = src_q[{issue_idx, 3'b000} +: 8];

    if (issue_vld) issue_cnt_d = issue_cnt_q + (IDX_W+1)'(1);
    if (wb_vld) result_d[{wb_idx, 3'b000} +: 8] = wb_byte;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          src_d       = in_data;
          mode_d      = in_dec;
          issue_cnt_d = '0;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (wb_vld && (wb_idx == IDX_W'(NBYTES - 1))) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      src_q       <= '0;
      result_q    <= '0;
      mode_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      src_q       <= src_d;
      result_q    <= result_d;
      mode_q      <= mode_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = result_q;

endmodule

// File: tb/tb_subbytes_serial.sv
// Self-checking bench for subbytes_serial against a table-driven AES S-box model.
module tb_subbytes_serial;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_dec;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  int total = 0;
  int bad   = 0;

  logic [7:0] sbox     [256];
  logic [7:0] inv_sbox [256];

  subbytes_serial dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dec    (in_dec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // S-box built from the generator-3 walk of GF(2^8), independent of the inversion datapath.
  task automatic build_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1B : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
    for (int i = 0; i < 256; i++) inv_sbox[sbox[i]] = 8'(i);
  endtask

  function automatic logic [127:0] ref_sub(input logic [127:0] d, input logic dec);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = dec ? inv_sbox[d[8*i +: 8]] : sbox[d[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_block(input logic [127:0] d, input logic dec);
    int n;
    n = 0;
    while (!in_ready && n < 60) begin
      tick();
      n++;
    end
    in_data  = d;
    in_dec   = dec;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    total++; if (out_data !== 128'h0) begin bad++; $display("FAIL reset out_data: got %h want 0", out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fwd_zero();
    int lat;
    accept_block(128'h0, 1'b0);
    wait_out(lat);
    total++; if (lat != 17) begin bad++; $display("FAIL fwd_zero latency: got %0d want 17", lat); end
    total++; if (out_data !== {16{8'h63}}) begin bad++; $display("FAIL fwd_zero data: got %h want %h", out_data, {16{8'h63}}); end
    tick();
  endtask

  task automatic test_inv_roundtrip();
    logic [127:0] d, r, exp;
    int lat;
    d = rand_block();
    d[31:0] = 32'h63ED7C16;
    exp = ref_sub(d, 1'b1);
    accept_block(d, 1'b1);
    wait_out(lat);
    r = out_data;
    total++; if (lat != 17) begin bad++; $display("FAIL inv latency: got %0d want 17", lat); end
    total++; if (r[31:0] !== 32'h0053_01FF) begin bad++; $display("FAIL inv low bytes: got %h want 005301ff", r[31:0]); end
    total++; if (r !== exp) begin bad++; $display("FAIL inv block: got %h want %h", r, exp); end
    tick();
    accept_block(r, 1'b0);
    wait_out(lat);
    total++; if (out_data !== d) begin bad++; $display("FAIL roundtrip: got %h want %h", out_data, d); end
    tick();
  endtask

  task automatic test_byte_order();
    logic [127:0] d;
    int lat;
    for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(i);
    accept_block(d, 1'b0);
    wait_out(lat);
    total++; if (out_data[7:0] !== 8'h63) begin bad++; $display("FAIL order byte0: got %h want 63", out_data[7:0]); end
    total++; if (out_data[15:8] !== 8'h7C) begin bad++; $display("FAIL order byte1: got %h want 7c", out_data[15:8]); end
    total++; if (out_data[127:120] !== 8'h76) begin bad++; $display("FAIL order byte15: got %h want 76", out_data[127:120]); end
    total++; if (out_data !== ref_sub(d, 1'b0)) begin bad++; $display("FAIL order block: got %h want %h", out_data, ref_sub(d, 1'b0)); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [127:0] d1, d2, snap;
    int lat;
    d1 = rand_block();
    d2 = rand_block();
    out_ready = 1'b0;
    accept_block(d1, 1'b0);
    wait_out(lat);
    snap = out_data;
    total++; if (snap !== ref_sub(d1, 1'b0)) begin bad++; $display("FAIL bp data: got %h want %h", snap, ref_sub(d1, 1'b0)); end
    in_data  = d2;
    in_dec   = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp out_valid cyc%0d: got %b want 1", c, out_valid); end
      total++; if (out_data !== snap) begin bad++; $display("FAIL bp stable cyc%0d: got %h want %h", c, out_data, snap); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp in_ready cyc%0d: got %b want 0", c, in_ready); end
    end
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp after hs out_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp after hs in_ready: got %b want 1", in_ready); end
    total++; if (out_data !== snap) begin bad++; $display("FAIL bp hold: got %h want %h", out_data, snap); end
    tick();
    in_valid = 1'b0;
    wait_out(lat);
    total++; if (lat != 17) begin bad++; $display("FAIL bp next latency: got %0d want 17", lat); end
    total++; if (out_data !== ref_sub(d2, 1'b1)) begin bad++; $display("FAIL bp next data: got %h want %h", out_data, ref_sub(d2, 1'b1)); end
    tick();
  endtask

  task automatic test_mode_latch();
    logic [127:0] d;
    logic m;
    int lat;
    for (int k = 0; k < 2; k++) begin
      d = rand_block();
      m = k[0];
      accept_block(d, m);
      lat = 0;
      for (int c = 0; c < 16 && !out_valid; c++) begin
        in_dec  = ~in_dec;
        in_data = rand_block();
        tick();
        lat++;
      end
      begin
        int rest;
        wait_out(rest);
        lat = (rest < 0) ? -1 : lat + rest;
      end
      total++; if (lat != 17) begin bad++; $display("FAIL mode latency k%0d: got %0d want 17", k, lat); end
      total++; if (out_data !== ref_sub(d, m)) begin bad++; $display("FAIL mode data k%0d: got %h want %h", k, out_data, ref_sub(d, m)); end
      tick();
    end
  endtask

  task automatic test_random();
    logic [127:0] d;
    logic m;
    int lat;
    for (int n = 0; n < 12; n++) begin
      d = rand_block();
      m = 1'($urandom_range(0, 1));
      out_ready = 1'b0;
      accept_block(d, m);
      wait_out(lat);
      total++; if (lat != 17) begin bad++; $display("FAIL rand latency n%0d: got %0d want 17", n, lat); end
      total++; if (out_data !== ref_sub(d, m)) begin bad++; $display("FAIL rand data n%0d: got %h want %h", n, out_data, ref_sub(d, m)); end
      repeat ($urandom_range(0, 3)) tick();
      out_ready = 1'b1;
      tick();
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    accept_block(rand_block(), 1'b1);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst out_valid: got %b want 0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst in_ready: got %b want 1", in_ready); end
    total++; if (out_data !== 128'h0) begin bad++; $display("FAIL midrst out_data: got %h want 0", out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    accept_block({16{8'h53}}, 1'b0);
    wait_out(lat);
    total++; if (lat != 17) begin bad++; $display("FAIL midrst next latency: got %0d want 17", lat); end
    total++; if (out_data !== {16{8'hED}}) begin bad++; $display("FAIL midrst next data: got %h want %h", out_data, {16{8'hED}}); end
    tick();
  endtask

  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    in_dec    = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    build_tables();
    test_reset();
    test_fwd_zero();
    test_inv_roundtrip();
    test_byte_order();
    test_backpressure();
    test_mode_latch();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
